jtcps2_objdma: RTL
==================

Name: jtcps2_objdma

Overview:
- Object-table DMA controller for the CPS2 main board.
- At each VBLANK start it requests the 68000 bus through the busreq/busack arbitration, copies the active object RAM bank word-by-word into the OBJ engine's internal table, then releases the bus.
- It is the sequencer behind the main CPU's busreq input: it owns the shared object RAM port while busack is high.

Parameters:
- WORDS, 1024, number of 16-bit words per transfer (256 objects × 4 words).
- AW, 10, index width; WORDS must be ≤ 2**AW.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset, asynchronous, active-low.
- cen  in  1  clock enable (cen16 rate); every state change is gated by cen.
- LVBL  in  1  vertical blank, active-low.
- obank  in  1  object bank select written by the CPU.
- busreq  out  1  bus request to the main CPU arbiter.
- busack  in  1  bus granted; CPU is off the bus.
- ram_cs  out  1  object RAM read strobe.
- ram_addr  out  13  object RAM word address {bank, 2'b00, idx}.
- ram_data  in  16  object RAM read data.
- ram_ok  in  1  read data valid.
- tbl_we  out  1  one-cycle write strobe into the OBJ table.
- tbl_addr  out  AW  OBJ table word address.
- tbl_din  out  16  OBJ table write data.
- busy  out  1  high from request until release.
- obj_cnt  out  AW+1  words written in the last completed transfer.

Behaviour:
- Reset values, all outputs: busreq=0, ram_cs=0, ram_addr=0, tbl_we=0, tbl_addr=0, tbl_din=0, busy=0, obj_cnt=0. State is IDLE.
- Trigger:
  - LVBL is registered every clk.
  - A falling edge (1→0) sets a pending flag. The flag is cleared on entering REQ.
  - A falling edge while busy is ignored; no queuing.
- FSM, all transitions on cen:
  - IDLE: if pending → REQ; latch bank_lat=obank; busreq=1; busy=1.
  - REQ: wait for busack=1 → READ, idx=0. There is no time limit unless the optional feature is compiled in.
  - READ: ram_cs=1; ram_addr={bank_lat,2'b00,idx}. ram_ok is ignored on the first cen after ram_addr changes (guards against stale ok from the previous access). When ram_ok=1 on a later cen: capture ram_data → WRITE.
  - WRITE: tbl_we=1 for exactly one clk. tbl_addr=idx. tbl_din=captured data. ram_cs stays high until this cycle, then drops.
    - If the end-marker is detected or idx==WORDS-1 → DONE.
    - Otherwise idx+1 → READ.
  - DONE: busreq=0; obj_cnt=idx+1. Wait for busack=0 → IDLE; busy=0.
- End-marker: a word with idx[1:0]==2'b01 and data[15:8]==8'hFF terminates the list. That word is still written. The remaining table words keep their previous contents.
- obank changes during a transfer do not affect it; only the bank_lat value is used.
- If busack drops during READ or WRITE, the transfer aborts: go to DONE, and obj_cnt holds the count of words written so far.
- idx never wraps: the final index is WORDS-1.
- Asynchronous reset at any point returns to IDLE with busreq=0 immediately. A partially written table is left as is.
- Latency: 2 cen from trigger to busreq (edge detect, then REQ). Minimum 3 cen per word.

Optional Feature:
- Macro JTCPS2_OBJDMA_TIMEOUT_EN.
- Defined: an 8-bit cen counter runs in REQ. If 255 cen elapse without busack, go to IDLE with busreq=0, skip this frame, and set a sticky timeout output port (1 bit, cleared by reset only).
- Undefined: REQ waits indefinitely; the port is absent.

Test Plan:
- Reset, then LVBL falls with busack tied to busreq delayed 4 cen, RAM fully populated with no marker → busreq rises 2 cen after the edge, exactly 1024 tbl_we pulses with tbl_addr 0..1023, obj_cnt=1024, busreq falls after idx 1023.
- obank=1, word 0x0005 holds 0xFF00 → reads use ram_addr 0x1000-0x1005, 6 writes, obj_cnt=6, table words ≥6 unchanged.
- ram_ok held high constantly → each word's data is taken no earlier than the second cen after the address change; captured values match the RAM model.
- Second LVBL falling edge injected mid-transfer → no extra transfer, and only one busreq pulse per frame.
- rstn asserted mid-READ at idx=300 → busreq=0, ram_cs=0, busy=0 immediately; the next frame restarts at idx 0.
- With JTCPS2_OBJDMA_TIMEOUT_EN, busack held 0 → busreq drops after 255 cen, timeout=1, and no tbl_we occurs.

Source files
------------

// File: rtl/jtcps2_objdma.sv
// jtcps2_objdma: object-table DMA, copies the active object RAM bank into the OBJ table at VBLANK.
// Ports: clk/rstn (async active-low), cen (state-change enable), LVBL (active-low vblank),
// obank (bank select), busreq/busack (68000 bus arbitration), ram_cs/ram_addr/ram_data/ram_ok
// (object RAM read port), tbl_we/tbl_addr/tbl_din (OBJ table write port), busy (request to
// release), obj_cnt (words written by the last transfer).
// Optional macro JTCPS2_OBJDMA_TIMEOUT_EN adds a REQ timeout and a sticky timeout output.
module jtcps2_objdma #(
    parameter int WORDS = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          cen,
    input  logic          LVBL,
    input  logic          obank,
    output logic          busreq,
    input  logic          busack,
    output logic          ram_cs,
    output logic [12:0]   ram_addr,
    input  logic [15:0]   ram_data,
    input  logic          ram_ok,
    output logic          tbl_we,
    output logic [AW-1:0] tbl_addr,
    output logic [15:0]   tbl_din,
    output logic          busy,
    output logic [AW:0]   obj_cnt
`ifdef JTCPS2_OBJDMA_TIMEOUT_EN
    ,
    output logic          timeout
`endif
);

    typedef enum logic [2:0] {IDLE, REQ, READ, WRITE, DONE} state_t;

    state_t        st;
    logic          lvbl_l, pending, bank_lat, armed, last;
    logic [AW-1:0] idx;
    logic          marker;
`ifdef JTCPS2_OBJDMA_TIMEOUT_EN
    logic [7:0]    tmr;
`endif

    // End-of-list word: second word of an object with 0xFF in its high byte
    assign marker = idx[1:0] == 2'b01 && ram_data[15:8] == 8'hFF;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st       <= IDLE;
            lvbl_l   <= 1'b0;
            pending  <= 1'b0;
            bank_lat <= 1'b0;
            armed    <= 1'b0;
            last     <= 1'b0;
            idx      <= '0;
            busreq   <= 1'b0;
            ram_cs   <= 1'b0;
            ram_addr <= '0;
            tbl_we   <= 1'b0;
            tbl_addr <= '0;
            tbl_din  <= '0;
            busy     <= 1'b0;
            obj_cnt  <= '0;
`ifdef JTCPS2_OBJDMA_TIMEOUT_EN
            tmr      <= '0;
            timeout  <= 1'b0;
`endif
        end else begin
            lvbl_l <= LVBL;
            tbl_we <= 1'b0;
            if (lvbl_l && !LVBL && !busy) pending <= 1'b1;
            // Read strobe is held through the table write clock, then released
            if (st == WRITE) ram_cs <= 1'b0;
            if (cen) begin
                case (st)
                    IDLE: if (pending) begin
                        st       <= REQ;
                        pending  <= 1'b0;
                        bank_lat <= obank;
                        busreq   <= 1'b1;
                        busy     <= 1'b1;
`ifdef JTCPS2_OBJDMA_TIMEOUT_EN
                        tmr      <= '0;
`endif
                    end
                    REQ: begin
                        if (busack) begin
                            st       <= READ;
                            idx      <= '0;
                            ram_cs   <= 1'b1;
                            ram_addr <= {bank_lat, 12'd0};
                            armed    <= 1'b0;
                        end
`ifdef JTCPS2_OBJDMA_TIMEOUT_EN
                        else if (tmr == 8'd254) begin
                            st      <= IDLE;
                            busreq  <= 1'b0;
                            busy    <= 1'b0;
                            timeout <= 1'b1;
                        end else tmr <= tmr + 8'd1;
`endif
                    end
                    READ: begin
                        // armed skips the first cen so a stale ok from the previous word is not taken
                        if (!busack) begin
                            st      <= DONE;
                            busreq  <= 1'b0;
                            ram_cs  <= 1'b0;
                            obj_cnt <= (AW+1)'(idx);
                        end else if (!armed) armed <= 1'b1;
                        else if (ram_ok) begin
                            st       <= WRITE;
                            tbl_we   <= 1'b1;
                            tbl_addr <= idx;
                            tbl_din  <= ram_data;
                            last     <= marker || idx == AW'(WORDS-1);
                        end
                    end
                    WRITE: begin
                        if (!busack || last) begin
                            st      <= DONE;
                            busreq  <= 1'b0;
                            ram_cs  <= 1'b0;
                            obj_cnt <= (AW+1)'(idx) + (AW+1)'(1);
                        end else begin
                            st       <= READ;
                            idx      <= idx + AW'(1);
                            ram_cs   <= 1'b1;
                            ram_addr <= {bank_lat, 12'(idx + AW'(1))};
                            armed    <= 1'b0;
                        end
                    end
                    DONE: if (!busack) begin
                        st   <= IDLE;
                        busy <= 1'b0;
                    end
                    default: st <= IDLE;
                endcase
            end
        end
    end

endmodule
